// File: rtl/fifo_pack.sv
// rtl/fifo_pack.sv - shared types and constants for the FIFO read-side drain controller
package fifo_pack;

    localparam int DEF_DATA_WIDTH = 8;
    localparam int DEF_CNT_WIDTH  = 16;
    localparam int SKID_DEPTH     = 2;

    typedef enum logic {
        RUN   = 1'b0,
        FLUSH = 1'b1
    } rd_state_e;

endpackage

// File: rtl/fifo_skid_buf.sv
// rtl/fifo_skid_buf.sv - 2-entry in-order skid buffer with push/pop/clear
module fifo_skid_buf
    import fifo_pack::*;
#(
    parameter int DATA_WIDTH = DEF_DATA_WIDTH
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  clear,
    input  logic                  push,
    input  logic [DATA_WIDTH-1:0] push_data,
    input  logic                  pop,
    output logic [1:0]            cnt,
    output logic [DATA_WIDTH-1:0] head_data
);

    logic [DATA_WIDTH-1:0] entry0;
    logic [DATA_WIDTH-1:0] entry1;

    // entry0 is always the head; a pop shifts entry1 forward
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt    <= 2'd0;
            entry0 <= '0;
            entry1 <= '0;
        end else if (clear) begin
            cnt <= 2'd0;
        end else begin
            case ({push, pop})
                2'b10: begin
                    if (cnt != 2'(SKID_DEPTH)) begin
                        if (cnt == 2'd0) entry0 <= push_data;
                        else             entry1 <= push_data;
                        cnt <= cnt + 2'd1;
                    end
                end
                2'b01: begin
                    entry0 <= entry1;
                    cnt    <= cnt - 2'd1;
                end
                2'b11: begin
                    if (cnt == 2'd1) begin
                        entry0 <= push_data;
                    end else begin
                        entry0 <= entry1;
                        entry1 <= push_data;
                    end
                end
                default: ;
            endcase
        end
    end

    assign head_data = entry0;

endmodule

// File: rtl/fifo_rd_ctrl.sv
// rtl/fifo_rd_ctrl.sv - FIFO read port to valid/ready stream drain controller with flush
// Optional statistics counters (rd_count, drop_count) under macro FIFO_RD_STATS_EN.
module fifo_rd_ctrl
    import fifo_pack::*;
#(
    parameter int DATA_WIDTH = DEF_DATA_WIDTH
`ifdef FIFO_RD_STATS_EN
    ,
    parameter int CNT_WIDTH  = DEF_CNT_WIDTH
`endif
) (
    input  logic                  rd_clk,
    input  logic                  rst,
    input  logic                  en,
    input  logic                  flush,
    output logic                  fifo_rd_en,
    input  logic [DATA_WIDTH-1:0] fifo_rd_data,
    input  logic                  fifo_empty,
    input  logic                  fifo_underflow,
    output logic                  m_valid,
    output logic [DATA_WIDTH-1:0] m_data,
    input  logic                  m_ready,
    output logic                  busy,
    output logic                  flush_done,
    output logic                  err_underflow
`ifdef FIFO_RD_STATS_EN
    ,
    output logic [CNT_WIDTH-1:0]  rd_count,
    output logic [CNT_WIDTH-1:0]  drop_count
`endif
);

    rd_state_e   state;
    rd_state_e   state_nxt;
    logic        inflight;
    logic [1:0]  skid_cnt;
    logic        skid_push;
    logic        skid_pop;
    logic        skid_clear;
    logic [2:0]  occ;

    fifo_skid_buf #(
        .DATA_WIDTH (DATA_WIDTH)
    ) u_skid (
        .clk       (rd_clk),
        .rst       (rst),
        .clear     (skid_clear),
        .push      (skid_push),
        .push_data (fifo_rd_data),
        .pop       (skid_pop),
        .cnt       (skid_cnt),
        .head_data (m_data)
    );

    assign m_valid  = (skid_cnt != 2'd0);
    assign skid_pop = m_valid && m_ready;
    // Slots committed after this edge; a read is only issued if one stays free
    assign occ      = {1'b0, skid_cnt} + {2'b00, inflight} - {2'b00, skid_pop};

    always_ff @(posedge rd_clk) begin
        if (rst) state <= RUN;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            RUN:     if (flush) state_nxt = FLUSH;
            FLUSH:   if (fifo_empty && !inflight) state_nxt = RUN;
            default: state_nxt = RUN;
        endcase
    end

    always_comb begin
        fifo_rd_en = 1'b0;
        flush_done = 1'b0;
        skid_push  = 1'b0;
        skid_clear = 1'b0;
        case (state)
            RUN: begin
                fifo_rd_en = en && !fifo_empty && (occ < 3'(SKID_DEPTH));
                skid_push  = inflight;
                skid_clear = flush;
            end
            FLUSH: begin
                fifo_rd_en = !fifo_empty;
                flush_done = fifo_empty && !inflight;
            end
            default: ;
        endcase
        if (rst) fifo_rd_en = 1'b0;
    end

    always_ff @(posedge rd_clk) begin
        if (rst) begin
            inflight      <= 1'b0;
            err_underflow <= 1'b0;
        end else begin
            inflight <= fifo_rd_en;
            if (fifo_underflow && inflight) err_underflow <= 1'b1;
        end
    end

    assign busy = (state == FLUSH) || (skid_cnt != 2'd0) || inflight;

`ifdef FIFO_RD_STATS_EN
    logic [1:0]         drop_inc;
    logic [CNT_WIDTH:0] drop_sum;

    // Flush entry drops what the skid still holds after this cycle's pop, plus the word landing now
    always_comb begin
        drop_inc = 2'd0;
        if (state == RUN && flush)
            drop_inc = skid_cnt - {1'b0, skid_pop} + {1'b0, inflight};
        else if (state == FLUSH && inflight)
            drop_inc = 2'd1;
    end

    assign drop_sum = {1'b0, drop_count} + {{(CNT_WIDTH-1){1'b0}}, drop_inc};

    always_ff @(posedge rd_clk) begin
        if (rst) begin
            rd_count   <= '0;
            drop_count <= '0;
        end else begin
            if (skid_pop && (rd_count != '1)) rd_count <= rd_count + CNT_WIDTH'(1);
            drop_count <= drop_sum[CNT_WIDTH] ? '1 : drop_sum[CNT_WIDTH-1:0];
        end
    end
`endif

endmodule
